// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring trace path.
// The trace_item_t layout depends on TRACE_COLLECTOR_TIMESTAMP_EN:
//   defined   : {gap, timestamp[63:0], pc[63:0], instr[31:0]}
//   undefined : {gap, pc[63:0], instr[31:0]}
package continuous_monitoring_system_pkg;

    localparam int TRACE_PC_WIDTH        = 64;
    localparam int TRACE_TIMESTAMP_WIDTH = 64;
    localparam int TRACE_INSTR_WIDTH     = 32;
    localparam int TRACE_FIFO_DEPTH      = 16;

    typedef struct packed {
        logic                              gap;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
        logic [TRACE_TIMESTAMP_WIDTH-1:0]  timestamp;
`endif
        logic [TRACE_PC_WIDTH-1:0]         pc;
        logic [TRACE_INSTR_WIDTH-1:0]      instr;
    } trace_item_t;

endpackage

// File: rtl/trace_item_fifo.sv
// Synchronous single-clock FIFO with a registered read-data stage.
// The head entry is copied into rd_data/rd_valid one cycle after it becomes
// available, so a write into an empty FIFO shows up on the output the cycle
// after the write (no write-to-read bypass). An entry stays counted in level
// until it is popped from the output register.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request; accepted when not full or popping
//   pop                consume the head (ignored unless rd_valid)
//   full, empty, level occupancy status (level has one extra MSB)
//   rd_valid, rd_data  registered head entry
module trace_item_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_cnt;
    logic [AW:0]      rd_cnt;
    logic [AW:0]      rd_next;
    logic             do_pop;
    logic             wr_en;
    logic             head_avail;

    assign level   = wr_cnt - rd_cnt;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && rd_valid;
    // A pop frees the slot in the same cycle, so a full FIFO still takes a write.
    assign wr_en   = push && (!full || do_pop);
    assign rd_next = rd_cnt + {{AW{1'b0}}, do_pop};
    // Compare against the pre-write count: an entry written this cycle is not
    // visible to the output stage until the next one.
    assign head_avail = (wr_cnt != rd_next);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_cnt   <= wr_cnt + {{AW{1'b0}}, wr_en};
            rd_cnt   <= rd_next;
            rd_valid <= head_avail;
            if (head_avail) begin
                rd_data <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/trace_item_collector.sv
// Trace item collector: pairs each retired PC/instruction with the trace
// filter's registered drop decision, buffers kept items and streams them
// out over valid/ready. Counts items lost to overflow and marks the first
// item accepted after a loss with gap=1.
// Optional feature macro: TRACE_COLLECTOR_TIMESTAMP_EN adds a 64-bit
// free-running cycle counter whose value at the decision cycle is stored
// in each item.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_valid, pc,     retired instruction (captured into hold registers)
//   instr
//   drop_instr        filter decision for the previously captured instruction
//   item_valid/ready  output handshake; item_data = head trace_item_t
//   fifo_level        occupancy
//   almost_full       level >= FIFO_DEPTH - AFULL_MARGIN (combinational)
//   overflow_count    saturating count of lost items
module trace_item_collector
    import continuous_monitoring_system_pkg::*;
#(
    parameter int FIFO_DEPTH    = TRACE_FIFO_DEPTH,
    parameter int AFULL_MARGIN  = 4,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pc_valid,
    input  logic [TRACE_PC_WIDTH-1:0]     pc,
    input  logic [TRACE_INSTR_WIDTH-1:0]  instr,
    input  logic                          drop_instr,
    output logic                          item_valid,
    input  logic                          item_ready,
    output logic [$bits(trace_item_t)-1:0] item_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          almost_full,
    output logic [OVF_CNT_WIDTH-1:0]      overflow_count
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] AFULL_THRESH = LW'(FIFO_DEPTH - AFULL_MARGIN);

    logic                          pending;
    logic [TRACE_PC_WIDTH-1:0]     hold_pc;
    logic [TRACE_INSTR_WIDTH-1:0]  hold_instr;
    logic                          gap_pending;
    logic                          push;
    logic                          pop;
    logic                          lost;
    logic                          fifo_full;
    logic                          fifo_empty;
    trace_item_t                   new_item;

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
    logic [TRACE_TIMESTAMP_WIDTH-1:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 64'd1;
    end
`endif

    // The decision arrives one cycle after capture, aligned with pending.
    assign push = pending && !drop_instr;
    assign pop  = item_valid && item_ready && !fifo_empty;
    assign lost = push && fifo_full && !pop;

    always_comb begin
        new_item       = '0;
        new_item.gap   = gap_pending;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
        new_item.timestamp = cycle_cnt;
`endif
        new_item.pc    = hold_pc;
        new_item.instr = hold_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= 1'b0;
            hold_pc        <= '0;
            hold_instr     <= '0;
            gap_pending    <= 1'b0;
            overflow_count <= '0;
        end else begin
            pending <= pc_valid;
            if (pc_valid) begin
                hold_pc    <= pc;
                hold_instr <= instr;
            end
            if (lost) begin
                gap_pending <= 1'b1;
                if (overflow_count != '1) begin
                    overflow_count <= overflow_count + {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else if (push) begin
                // Any push that is not lost is accepted and carries the gap flag.
                gap_pending <= 1'b0;
            end
        end
    end

    trace_item_fifo #(
        .WIDTH ($bits(trace_item_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (new_item),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .rd_valid  (item_valid),
        .rd_data   (item_data)
    );

    assign almost_full = (fifo_level >= AFULL_THRESH);

endmodule

// File: tb/tb_trace_item_collector.sv
module tb_trace_item_collector;
    import continuous_monitoring_system_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          pc_valid;
    logic [63:0]                   pc;
    logic [31:0]                   instr;
    logic                          drop_instr;
    logic                          item_valid;
    logic                          item_ready;
    logic [$bits(trace_item_t)-1:0] item_data;
    logic [4:0]                    fifo_level;
    logic                          almost_full;
    logic [15:0]                   overflow_count;

    typedef struct {
        logic        gap;
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    logic   prev_drop = 1'b1;
    logic   stalled = 1'b0;
    logic [$bits(trace_item_t)-1:0] stall_data;

    trace_item_collector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .instr          (instr),
        .drop_instr     (drop_instr),
        .item_valid     (item_valid),
        .item_ready     (item_ready),
        .item_data      (item_data),
        .fifo_level     (fifo_level),
        .almost_full    (almost_full),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_item(input logic g, input logic [63:0] p, input logic [31:0] i);
        exp_t e;
        e.gap = g; e.pc = p; e.instr = i;
        q.push_back(e);
    endtask

    // Item N's drop decision is presented in the cycle after its pc_valid.
    task automatic send(input logic [63:0] p, input logic [31:0] i, input logic d);
        @(posedge clk); #1;
        pc_valid = 1'b1; pc = p; instr = i;
        drop_instr = prev_drop;
        prev_drop = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pc_valid = 1'b0;
            drop_instr = prev_drop;
            prev_drop = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        item_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d items still expected", name, q.size());
            q.delete();
        end
        @(posedge clk); #1;
        chk({name, " level after drain"}, 128'(fifo_level), 128'd0);
    endtask

    // Monitor: compares every accepted item against the scoreboard and
    // checks that a stalled item is held stable.
    always @(negedge clk) begin
        trace_item_t got;
        exp_t        e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!item_valid || item_data !== stall_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%0h expected held %0h", item_valid, item_data, stall_data);
                end
            end
            if (item_valid && item_ready) begin
                got = item_data;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected item: pc=%0h instr=%0h", got.pc, got.instr);
                end else begin
                    e = q.pop_front();
                    if (got.gap !== e.gap || got.pc !== e.pc || got.instr !== e.instr) begin
                        errors++;
                        $display("FAIL item: got gap=%0b pc=%0h instr=%0h expected gap=%0b pc=%0h instr=%0h",
                                 got.gap, got.pc, got.instr, e.gap, e.pc, e.instr);
                    end
                end
            end
            stalled    = item_valid && !item_ready;
            stall_data = item_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_valid = 1'b0; pc = '0; instr = '0;
        drop_instr = 1'b0; item_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset item_valid", 128'(item_valid), 128'd0);
        chk("reset item_data", 128'(item_data), 128'd0);
        chk("reset level", 128'(fifo_level), 128'd0);
        chk("reset almost_full", 128'(almost_full), 128'd0);
        chk("reset overflow", 128'(overflow_count), 128'd0);
        rst_n = 1'b1;

        // Single kept item: valid rises 3 cycles after pc_valid.
        send(64'h8000_0000, 32'h0000_0063, 1'b0);       // t0
        expect_item(1'b0, 64'h8000_0000, 32'h0000_0063);
        idle(1);                                         // t1: decision
        chk("single valid t1", 128'(item_valid), 128'd0);
        idle(1);                                         // t2
        chk("single level t2", 128'(fifo_level), 128'd1);
        chk("single valid t2", 128'(item_valid), 128'd0);
        idle(1);                                         // t3
        chk("single valid t3", 128'(item_valid), 128'd1);
        wait_drain("single");

        // Dropped item.
        send(64'h8000_0004, 32'h0000_0013, 1'b1);
        idle(4);
        chk("drop level", 128'(fifo_level), 128'd0);
        chk("drop valid", 128'(item_valid), 128'd0);
        chk("drop overflow", 128'(overflow_count), 128'd0);

        // Overflow: 20 kept items into 16 entries with no consumer.
        item_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(64'h1000 + 64'(i*4), 32'(32'h100 + i), 1'b0);
            if (i < 16) expect_item(1'b0, 64'h1000 + 64'(i*4), 32'(32'h100 + i));
        end
        idle(4);
        chk("ovf level", 128'(fifo_level), 128'd16);
        chk("ovf count", 128'(overflow_count), 128'd4);
        chk("ovf almost_full", 128'(almost_full), 128'd1);
        wait_drain("ovf");
        send(64'h2000, 32'h200, 1'b0);
        send(64'h2004, 32'h201, 1'b0);
        expect_item(1'b1, 64'h2000, 32'h200);
        expect_item(1'b0, 64'h2004, 32'h201);
        idle(1);
        wait_drain("gap");

        // Full with a same-cycle pop: push is accepted, level stays 16.
        item_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(64'h3000 + 64'(i*4), 32'(32'h300 + i), 1'b0);
            expect_item(1'b0, 64'h3000 + 64'(i*4), 32'(32'h300 + i));
        end
        idle(4);
        chk("fullpop level before", 128'(fifo_level), 128'd16);
        send(64'h3100, 32'h3ff, 1'b0);
        expect_item(1'b0, 64'h3100, 32'h3ff);
        @(posedge clk); #1;
        pc_valid = 1'b0; drop_instr = prev_drop; prev_drop = 1'b1;
        item_ready = 1'b1;
        @(posedge clk); #1;
        item_ready = 1'b0;
        chk("fullpop level after", 128'(fifo_level), 128'd16);
        chk("fullpop overflow", 128'(overflow_count), 128'd4);
        wait_drain("fullpop");

        // Backpressure: ready toggles every cycle while 8 items stream.
        item_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(64'h4000 + 64'(i*4), 32'(32'h400 + i), 1'b0);
                    expect_item(1'b0, 64'h4000 + 64'(i*4), 32'(32'h400 + i));
                end
                idle(1);
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    item_ready = ~item_ready;
                end
            end
        join
        wait_drain("bp");

        // Reset mid-stream with 7 items buffered.
        item_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(64'h5000 + 64'(i*4), 32'(32'h500 + i), 1'b0);
        end
        idle(4);
        chk("rst level before", 128'(fifo_level), 128'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst item_valid", 128'(item_valid), 128'd0);
        chk("rst level", 128'(fifo_level), 128'd0);
        chk("rst overflow", 128'(overflow_count), 128'd0);
        chk("rst almost_full", 128'(almost_full), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clean operation after reset.
        send(64'h6000, 32'h600, 1'b0);
        expect_item(1'b0, 64'h6000, 32'h600);
        idle(1);
        wait_drain("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
